serial_borrow_sub: RTL
======================

Name: serial_borrow_sub

Overview:
- Multi-cycle bit-serial subtractor: computes diff = a - b - bin over WIDTH cycles, one bit per cycle.
- Uses per-bit borrow generate (g = ~a & b) and propagate (p = ~(a ^ b)) terms, the subtract-direction counterpart of the adder carry-lookahead slices.
- Sits beside the CLA datapath as the area-cheap subtract/compare engine, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b, bin are valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts the result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow-out; 1 when a < b + bin (unsigned)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- On reset: state = IDLE, in_ready = 1, out_valid = 0, diff = 0, bout = 0, bit counter = 0, all operand registers = 0. The optional ovf output also resets to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid & in_ready in cycle T: latch a, b, bin; set the borrow register to bin; clear the counter; go to RUN.
  - in_valid low: stay in IDLE.
- RUN:
  - in_ready = 0.
  - Each cycle processes bit i = counter, LSB first.
  - d_i = a_i ^ b_i ^ br.
  - br_next = g_i | (p_i & br).
  - d_i is written into diff[i]; the counter increments.
  - After bit WIDTH-1, set bout = br_next and go to DONE.
  - Exactly WIDTH cycles are spent in RUN.
- DONE:
  - out_valid = 1, held until out_ready.
  - diff and bout stay stable while out_valid = 1 and out_ready = 0.
  - When out_valid & out_ready: go to IDLE; out_valid drops next cycle.
  - in_ready stays 0 in DONE, so there is no same-cycle accept.
- Latency: accept in cycle T; out_valid first high in cycle T+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles when out_ready is held high.
- diff bits not yet computed during RUN hold their previous values. Consumers sample diff only when out_valid = 1.
- Operand inputs are ignored outside an IDLE accept. Changing a or b during RUN has no effect on the result.
- Boundary cases:
  - a == b, bin = 0 gives diff = 0, bout = 0.
  - a = 0, b = 0, bin = 1 wraps to diff = all ones, bout = 1.
  - a = 0, b = all ones, bin = 1 gives diff = 0, bout = 1.
- rst asserted in any state, including mid-RUN or in DONE with out_ready low:
  - Returns to IDLE with reset values on the next edge.
  - The partial result is discarded; no out_valid pulse is produced.
- in_valid and rst high in the same cycle: reset wins; operands are not accepted.

Optional Feature:
- Macro: SUB_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow of a - b - bin.
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), registered together with bout on entry to DONE.
  - Valid under out_valid; reset value 0.
- Not defined: port ovf does not exist; all other behaviour is identical.

Test Plan:
- Basic subtract, WIDTH=8: a=0x05, b=0x03, bin=0, out_ready=1.
  - Required: diff=0x02, bout=0.
  - out_valid high exactly 9 cycles after the accept cycle, for 1 cycle.
- Unsigned underflow: a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1.
- Borrow-in wrap: a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- Back-pressure: a=0xA0, b=0x0F, out_ready=0 for 5 cycles after out_valid.
  - Required: diff=0x91, bout=0, stable throughout; in_ready=0 throughout.
  - After out_ready=1: IDLE and in_ready=1 on the next cycle.
- Reset mid-operation: accept a=0x55, b=0x11, pulse rst in RUN cycle 4.
  - Required: state IDLE, outputs at reset values, no out_valid.
  - Follow-up a=0x10, b=0x01 → diff=0x0F, bout=0.
- With SUB_OVERFLOW_FLAG_EN:
  - a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0x01 → diff=0x7E, ovf=0.

Source files
------------

// File: rtl/serial_borrow_sub.sv
// serial_borrow_sub: bit-serial a - b - bin, one bit per clock, LSB first.
// Optional SUB_OVERFLOW_FLAG_EN adds a signed overflow output ovf.
module serial_borrow_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SUB_OVERFLOW_FLAG_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW  = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic            br;
   logic [CW-1:0]   cnt;

   logic a_i;
   logic b_i;
   logic g_i;
   logic p_i;
   logic d_i;
   logic br_next;
   logic last;

   // current bit slice: difference bit and borrow generate/propagate
   always_comb begin
      a_i     = a_q[cnt];
      b_i     = b_q[cnt];
      g_i     = ~a_i & b_i;
      p_i     = ~(a_i ^ b_i);
      d_i     = a_i ^ b_i ^ br;
      br_next = g_i | (p_i & br);
      last    = (cnt == CW'(WIDTH - 1));
   end

   // control FSM with registered handshake outputs and result bits
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         diff      <= '0;
         bout      <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         br        <= 1'b0;
         cnt       <= '0;
`ifdef SUB_OVERFLOW_FLAG_EN
         ovf       <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_q      <= a;
                  b_q      <= b;
                  br       <= bin;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               diff[cnt] <= d_i;
               br        <= br_next;
               cnt       <= cnt + CW'(1);
               if (last) begin
                  bout      <= br_next;
`ifdef SUB_OVERFLOW_FLAG_EN
                  ovf       <= (a_q[MSB] != b_q[MSB]) &&
                               (d_i != a_q[MSB]);
`endif
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
